game_tick_gen: RTL and testbench
================================

GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 25: width of the period counter and period registers.
REQ-002 SHALL have parameter NUM_LEVELS, default 8: number of speed levels; LVL_W = $clog2(NUM_LEVELS).
REQ-003 SHALL have parameter BASE_PERIOD, default 25_000_000: tick period in clk cycles at level 0.
REQ-004 SHALL have parameter STEP_PERIOD, default 2_500_000: period reduction per level.
REQ-005 SHALL have parameter MIN_PERIOD, default 5_000_000: floor on the period; MIN_PERIOD >= 2.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1: run request (1 = run, 0 = pause).
REQ-009 SHALL have port step, input, 1: single-tick request, honoured only while in PAUSE.
REQ-010 SHALL have port level_up, input, 1: one-cycle pulse that increments the speed level.
REQ-011 SHALL have port level_set, input, 1: load the speed level from level_val.
REQ-012 SHALL have port level_val, input, LVL_W: level value loaded by level_set.
REQ-013 SHALL have port tick, output, 1: one-cycle pulse per game step.
REQ-014 SHALL have port game_clock, output, 1: square wave that toggles on every tick.
REQ-015 SHALL have port level, output, LVL_W: current speed level.
REQ-016 SHALL have port paused, output, 1: high in IDLE and PAUSE.

Function
REQ-017 SHALL compute period(L) = max(BASE_PERIOD - L*STEP_PERIOD, MIN_PERIOD), evaluated at CNT_W+LVL_W bits so the subtraction never wraps.
REQ-018 SHALL implement states IDLE, RUN and PAUSE.
- IDLE -> RUN when enable = 1.
- RUN -> PAUSE when enable = 0.
- PAUSE -> RUN when enable = 1.
REQ-019 SHALL, on IDLE -> RUN, clear the counter and latch period_q = period(level).
REQ-020 SHALL, in RUN, count 0..period_q-1.
- At count period_q-1: assert tick (registered) for exactly one cycle, wrap the count to 0, reload period_q = period(level).
- The first tick occurs period_q cycles after the RUN-entry edge.
REQ-021 SHALL, in PAUSE, hold the counter and period_q, and keep tick = 0.
REQ-022 SHALL, on PAUSE -> RUN, resume counting from the held value, so no elapsed cycles are lost.
REQ-023 SHALL, when step = 1 in PAUSE with enable = 0, pulse tick on the next cycle, clear the counter and remain in PAUSE.
- step is ignored in IDLE and RUN.
REQ-024 SHALL let a level change take effect only at the next period reload; the period in progress completes at its old length.
REQ-025 SHALL saturate level_up at NUM_LEVELS-1.
REQ-026 SHALL let level_set override level_up when both are asserted in the same cycle.
REQ-027 SHALL clamp a level_val >= NUM_LEVELS to NUM_LEVELS-1.
REQ-028 SHALL accept level_up and level_set in every state, including PAUSE and IDLE.
REQ-029 SHALL toggle game_clock in the same cycle tick is asserted, giving a frequency of tick_rate/2.

Reset
REQ-030 SHALL, on reset, asynchronously force:
- state = IDLE, counter = 0, period_q = BASE_PERIOD, level = 0;
- tick = 0, game_clock = 0, paused = 1.
REQ-031 SHALL, if reset is asserted mid-period, discard the partial count.
- After release, the first tick occurs a full period(0) after RUN entry.

Structure
REQ-032 SHALL place the state enum, the default parameter constants, and a period-of-level function in shared package game_pkg.
REQ-033 SHALL be a single module with no sub-modules; the period computation is one registered function call.

Verification
All scenarios use CNT_W=8, NUM_LEVELS=4, BASE_PERIOD=10, STEP_PERIOD=3, MIN_PERIOD=5.
REQ-034 SHALL check free-run: release reset, enable = 1 -> tick at 10, 20, 30 cycles after RUN entry; game_clock toggles 0->1->0->1.
REQ-035 SHALL check level ramp: level_up pulsed 4 times -> level saturates at 3.
- Periods after each reload are 7, then 5 (level 2 and 3 both give 5, the floor); the change applies only after the current tick.
REQ-036 SHALL check pause and step:
- enable = 0 at count 4 -> no ticks, paused = 1.
- step -> tick next cycle, counter = 0.
- enable = 1 -> next tick after a full period.
REQ-037 SHALL check simultaneous requests: level_up and level_set with level_val = 1 in the same cycle -> level = 1.
- level_set with level_val = 3 -> level = 3.
REQ-038 SHALL check reset mid-period: reset asserted at count 6 -> all outputs at reset values immediately.
- After release with enable = 1 -> first tick 10 cycles after RUN entry.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_pkg : shared state encoding, default constants, period fn     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package game_pkg;

  localparam int DEF_CNT_W       = 25;
  localparam int DEF_NUM_LEVELS  = 8;
  localparam int DEF_BASE_PERIOD = 25_000_000;
  localparam int DEF_STEP_PERIOD = 2_500_000;
  localparam int DEF_MIN_PERIOD  = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Evaluated wide and compared before subtracting, so a large level never wraps.
  function automatic logic [63:0] period_of(input logic [63:0] lvl,
                                            input logic [63:0] base,
                                            input logic [63:0] step,
                                            input logic [63:0] floor);
    logic [63:0] dec;
    dec = lvl * step;
    if (dec + floor >= base) return floor;
    return base - dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_tick_gen : level-scaled game tick with run/pause/single-step  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module game_tick_gen
  import game_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_LEVELS  = DEF_NUM_LEVELS,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  localparam int LVL_W      = $clog2(NUM_LEVELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic             level_up,
  input  logic             level_set,
  input  logic [LVL_W-1:0] level_val,
  output logic             tick,
  output logic             game_clock,
  output logic [LVL_W-1:0] level,
  output logic             paused
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               tick_q, tick_d;
  logic               game_clock_q, game_clock_d;
  logic [CNT_W-1:0]   period_new;

  assign period_new = CNT_W'(period_of(64'(level_q), 64'(BASE_PERIOD),
                                       64'(STEP_PERIOD), 64'(MIN_PERIOD)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          period_d = period_new;
        end
      end
      ST_RUN: begin
        // The cycle in which enable drops still counts, so pausing loses no time.
        if (cnt_q == period_q - CNT_W'(1)) begin
          tick_d   = 1'b1;
          cnt_d    = '0;
          period_d = period_new;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!enable) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (step) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (level_set) begin
      level_d = (level_val > MAX_LVL) ? MAX_LVL : level_val;
    end else if (level_up && (level_q != MAX_LVL)) begin
      level_d = level_q + LVL_W'(1);
    end
  end

  assign game_clock_d = game_clock_q ^ tick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      period_q     <= CNT_W'(BASE_PERIOD);
      level_q      <= '0;
      tick_q       <= 1'b0;
      game_clock_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      level_q      <= level_d;
      tick_q       <= tick_d;
      game_clock_q <= game_clock_d;
    end
  end

  assign tick       = tick_q;
  assign game_clock = game_clock_q;
  assign level      = level_q;
  assign paused     = (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_game_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_game_tick_gen : scoreboard bench against a countdown model      |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_game_tick_gen;

  localparam int CNT_W = 8;
  localparam int NL    = 4;
  localparam int BASE  = 10;
  localparam int STEPP = 3;
  localparam int MINP  = 5;
  localparam int LW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          step = 1'b0;
  logic          level_up = 1'b0;
  logic          level_set = 1'b0;
  logic [LW-1:0] level_val = '0;
  logic          tick;
  logic          game_clock;
  logic [LW-1:0] level;
  logic          paused;

  always #5 clk = ~clk;

  game_tick_gen #(
    .CNT_W(CNT_W), .NUM_LEVELS(NL), .BASE_PERIOD(BASE),
    .STEP_PERIOD(STEPP), .MIN_PERIOD(MINP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .level_up(level_up), .level_set(level_set), .level_val(level_val),
    .tick(tick), .game_clock(game_clock), .level(level), .paused(paused)
  );

  typedef struct {
    bit tick;
    bit paused;
    bit gclk;
    int level;
  } status_t;

  status_t sq[$];
  bit      tq[$];
  status_t mon_e;
  int      errors = 0;
  int      checks = 0;

  // Reference model: mode 0=idle 1=run 2=pause; counts down the cycles left in a period.
  int m_mode, m_remaining, m_period, m_level;
  bit m_gclk;

  function automatic int period_for(int l);
    int p;
    p = BASE - l * STEPP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_remaining = 0; m_period = BASE; m_level = 0; m_gclk = 1'b0;
    sq.delete();
    tq.delete();
  endtask

  task automatic model_step(bit en, bit st, bit up, bit set, int val);
    bit t;
    int nl;
    t = 1'b0;
    case (m_mode)
      0: if (en) begin
           m_mode = 1; m_period = period_for(m_level); m_remaining = m_period;
         end
      1: begin
           m_remaining--;
           if (m_remaining == 0) begin
             t = 1'b1; m_period = period_for(m_level); m_remaining = m_period;
           end
           if (!en) m_mode = 2;
         end
      default: if (en) m_mode = 1;
               else if (st) begin t = 1'b1; m_remaining = m_period; end
    endcase
    nl = m_level;
    if (set) nl = (val > NL - 1) ? NL - 1 : val;
    else if (up && m_level < NL - 1) nl = m_level + 1;
    m_level = nl;
    if (t) begin
      m_gclk = !m_gclk;
      tq.push_back(m_gclk);
    end
    sq.push_back('{t, (m_mode != 1), m_gclk, m_level});
  endtask

  task automatic cycle(bit en, bit st, bit up, bit set, int val);
    @(negedge clk);
    enable = en; step = st; level_up = up; level_set = set; level_val = LW'(val);
    model_step(en, st, up, set, val);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0; step = 1'b0; level_up = 1'b0; level_set = 1'b0; level_val = '0;
    #1;
    check("rst_tick", int'(tick), 0);
    check("rst_game_clock", int'(game_clock), 0);
    check("rst_level", int'(level), 0);
    check("rst_paused", int'(paused), 1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && sq.size() > 0) begin
      mon_e = sq.pop_front();
      check("tick", int'(tick), int'(mon_e.tick));
      check("paused", int'(paused), int'(mon_e.paused));
      check("level", int'(level), mon_e.level);
      check("game_clock_level", int'(game_clock), int'(mon_e.gclk));
      if (tick) begin
        if (tq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_unexpected: got tick=1 expected no pending tick (t=%0t)", $time);
        end else begin
          check("tick_game_clock", int'(game_clock), int'(tq.pop_front()));
        end
      end
    end
  end

  initial begin
    do_reset();

    // free run at level 0: ticks every 10 cycles
    repeat (35) cycle(1, 0, 0, 0, 0);

    // level ramp with saturation at 3
    repeat (4) begin
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 0);
    end
    repeat (30) cycle(1, 0, 0, 0, 0);

    // pause around count 4, single step, resume
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (15) cycle(1, 0, 0, 0, 0);

    // level_set wins over level_up; level_val 3
    cycle(1, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 3);
    repeat (8) cycle(1, 0, 0, 0, 0);

    // reset at count 6, then a full level-0 period
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0, 0);
    do_reset();
    repeat (12) cycle(1, 0, 0, 0, 0);

    // randomized traffic
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
              int'($urandom_range(0, 3)));
      end
    end

    repeat (2) @(negedge clk);
    check("tick_queue_drained", tq.size(), 0);
    check("status_queue_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
